// File: rtl/silencer_pkg.sv
// silencer_pkg: shared types and helpers for the fixed-step silencer.
// Holds the FSM state type, the circular phase step and the depth check.
package silencer_pkg;

   typedef enum logic {INIT, READY} state_t;

   function automatic bit depth_ok(input int depth);
      return (depth >= 3) && (depth <= 256);
   endfunction

   // Shortest-path circular move; an exact half turn goes down.
   function automatic logic [7:0] phase_delta(
      input logic [7:0] current,
      input logic [7:0] target,
      input logic [7:0] step
   );
      logic [7:0] up;
      logic [7:0] dn;
      logic [7:0] mv;
      up = target - current;
      dn = 8'd0 - up;
      if (step == 8'd0) return target;
      if (up == 8'd0) return current;
      if (!up[7]) begin
         mv = (step < up) ? step : up;
         return current + mv;
      end
      mv = (step < dn) ? step : dn;
      return current - mv;
   endfunction

endpackage

// File: rtl/silencer_step_unit.sv
// silencer_step_unit: one channel of the per-frame slew limiter.
// Linear channels saturate at target; circular ones wrap mod 256.
module silencer_step_unit
   import silencer_pkg::*;
#(
   parameter bit CIRCULAR = 1'b0
) (
   input  logic [7:0] current,
   input  logic [7:0] target,
   input  logic [7:0] step,
   output logic [7:0] result
);

   if (CIRCULAR) begin : g_circ
      assign result = phase_delta(current, target, step);
   end else begin : g_lin
      logic signed [8:0] diff;
      logic [8:0]        mag;

      // Clamp the signed distance to the step, or jump when bypassed.
      always_comb begin
         diff = $signed({1'b0, target}) - $signed({1'b0, current});
         mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
         if (step == 8'd0 || mag <= {1'b0, step}) begin
            result = target;
         end else if (diff[8]) begin
            result = current - step;
         end else begin
            result = current + step;
         end
      end
   end

endmodule

// File: rtl/silencer_fixed_step.sv
// silencer_fixed_step: per-transducer slew limiter, two-stage pipeline.
// State RAM holds the current intensity/phase and is cleared by INIT.
module silencer_fixed_step
   import silencer_pkg::*;
#(
   parameter int DEPTH = 249,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic [7:0]    STEP_INTENSITY,
   input  logic [7:0]    STEP_PHASE,
   input  logic          DIN_VALID,
   input  logic [7:0]    INTENSITY_IN,
   input  logic [7:0]    PHASE_IN,
   output logic          DOUT_VALID,
   output logic [IW-1:0] DOUT_IDX,
   output logic [7:0]    INTENSITY_OUT,
   output logic [7:0]    PHASE_OUT,
   output logic          BUSY
);

   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("silencer_fixed_step: DEPTH must be 3..256");
   end

   state_t        state;
   logic [IW-1:0] init_addr;
   logic [IW-1:0] idx;
   logic [7:0]    step_i;
   logic [7:0]    step_p;

   logic          s1_valid;
   logic [IW-1:0] s1_idx;
   logic [7:0]    s1_tgt_i;
   logic [7:0]    s1_tgt_p;
   logic [7:0]    s1_step_i;
   logic [7:0]    s1_step_p;
   logic [7:0]    s1_cur_i;
   logic [7:0]    s1_cur_p;

   logic [15:0]   mem [DEPTH];

   logic          beat;
   logic          first;
   logic [7:0]    eff_i;
   logic [7:0]    eff_p;
   logic [7:0]    nxt_i;
   logic [7:0]    nxt_p;
   logic          we;
   logic [IW-1:0] waddr;
   logic [15:0]   wdata;

   assign beat  = DIN_VALID && (state == READY);
   assign first = (idx == '0);
   assign eff_i = first ? STEP_INTENSITY : step_i;
   assign eff_p = first ? STEP_PHASE : step_p;

   assign we    = (state == INIT) || s1_valid;
   assign waddr = (state == INIT) ? init_addr : s1_idx;
   assign wdata = (state == INIT) ? 16'd0 : {nxt_i, nxt_p};

   // INIT walks every address once, then hands over to READY.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= INIT;
         init_addr <= '0;
         BUSY      <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               if (init_addr == LAST) begin
                  state <= READY;
                  BUSY  <= 1'b0;
               end else begin
                  init_addr <= init_addr + IW'(1);
               end
            end
            READY: state <= READY;
            default: state <= INIT;
         endcase
      end
   end

   // Frame position counter; steps are captured on the index-0 beat.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         idx    <= '0;
         step_i <= '0;
         step_p <= '0;
      end else if (beat) begin
         idx <= (idx == LAST) ? '0 : idx + IW'(1);
         if (first) begin
            step_i <= STEP_INTENSITY;
            step_p <= STEP_PHASE;
         end
      end else begin
         idx <= '0;
      end
   end

   // Stage 1: capture the beat and read its stored current value.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_valid  <= 1'b0;
         s1_idx    <= '0;
         s1_tgt_i  <= '0;
         s1_tgt_p  <= '0;
         s1_step_i <= '0;
         s1_step_p <= '0;
         s1_cur_i  <= '0;
         s1_cur_p  <= '0;
      end else begin
         s1_valid <= beat;
         if (beat) begin
            s1_idx                 <= idx;
            s1_tgt_i               <= INTENSITY_IN;
            s1_tgt_p               <= PHASE_IN;
            s1_step_i              <= eff_i;
            s1_step_p              <= eff_p;
            {s1_cur_i, s1_cur_p}   <= mem[idx];
         end
      end
   end

   silencer_step_unit #(.CIRCULAR(1'b0)) u_intensity (
      .current (s1_cur_i),
      .target  (s1_tgt_i),
      .step    (s1_step_i),
      .result  (nxt_i)
   );

   silencer_step_unit #(.CIRCULAR(1'b1)) u_phase (
      .current (s1_cur_p),
      .target  (s1_tgt_p),
      .step    (s1_step_p),
      .result  (nxt_p)
   );

   // State RAM write port: zero fill during INIT, write-back after.
   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   // Stage 2: register the slewed pair onto the outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DOUT_VALID    <= 1'b0;
         DOUT_IDX      <= '0;
         INTENSITY_OUT <= '0;
         PHASE_OUT     <= '0;
      end else begin
         DOUT_VALID <= s1_valid;
         if (s1_valid) begin
            DOUT_IDX      <= s1_idx;
            INTENSITY_OUT <= nxt_i;
            PHASE_OUT     <= nxt_p;
         end
      end
   end

endmodule
